// File: rtl/sdio_rx_pingpong.sv
// Two-slot (ping-pong) receive byte buffer between the SDIO data deserializer and sdio_dma.
// Define SDIO_RXBUF_OVF_CNT_EN to build the saturating dropped-byte counter (ovf_cnt).
module sdio_rx_pingpong #(
  parameter int LEN = 16
) (
  input  logic           bus_clk,
  input  logic           rstn,
  input  logic           buf_rst,
  input  logic           rx_start,
  input  logic [LEN-1:0] blk_len,
  input  logic           rx_byte_en,
  input  logic [7:0]     rx_byte,
  input  logic           buf_free,
  output logic [7:0]     buf0,
  output logic [7:0]     buf1,
  output logic           buf0_rd_rdy,
  output logic           buf1_rd_rdy,
  output logic           rx_ready,
  output logic           rx_ovf,
  output logic           dma_end,
  output logic [LEN-1:0] rx_cnt,
  output logic [7:0]     ovf_cnt,
  output logic [1:0]     rx_state
);

  // state | meaning
  // IDLE  | waiting for rx_start
  // RECV  | accepting bytes until rx_cnt reaches len_q
  // DRAIN | waiting for the DMA to empty both slots
  // DONE  | one cycle; dma_end is registered from this state
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } st_t;

  st_t            st, st_nxt;
  logic           dma_end_nxt;
  logic [LEN-1:0] len_q;
  logic           wr_ptr, rd_ptr;
  logic [1:0]     rdy, rdy_nxt;
  logic           free_ok, slot_open, recv_more, accept, drop, start_ok;

  assign buf0_rd_rdy = rdy[0];
  assign buf1_rd_rdy = rdy[1];
  assign rx_state    = st;

  // A free of a slot that holds nothing is a DMA protocol error and is ignored.
  assign free_ok   = buf_free & rdy[rd_ptr];
  assign slot_open = ~rdy[wr_ptr] | (buf_free & (rd_ptr == wr_ptr));
  assign recv_more = (st == RECV) & (rx_cnt != len_q);
  assign accept    = recv_more & rx_byte_en & slot_open;
  assign drop      = recv_more & rx_byte_en & ~slot_open;
  assign start_ok  = (st == IDLE) & rx_start;
  assign rx_ready  = (st == RECV) & slot_open;

  always_comb begin
    st_nxt      = st;
    dma_end_nxt = 1'b0;
    case (st)
      IDLE:    if (rx_start) st_nxt = RECV;
      RECV:    if (rx_cnt == len_q) st_nxt = DRAIN;
      DRAIN:   if (rdy == 2'b00) st_nxt = DONE;
      DONE: begin
        dma_end_nxt = 1'b1;
        st_nxt      = IDLE;
      end
      default: st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge bus_clk or negedge rstn) begin
    if (!rstn)        st <= IDLE;
    else if (buf_rst) st <= IDLE;
    else              st <= st_nxt;
  end

  // Free is applied before the write, so a same-cycle free+write of one slot leaves it ready.
  always_comb begin
    rdy_nxt = rdy;
    if (free_ok) rdy_nxt[rd_ptr] = 1'b0;
    if (accept)  rdy_nxt[wr_ptr] = 1'b1;
  end

  always_ff @(posedge bus_clk or negedge rstn) begin
    if (!rstn) begin
      len_q   <= '0;
      rx_cnt  <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      rdy     <= 2'b00;
      buf0    <= 8'h00;
      buf1    <= 8'h00;
      rx_ovf  <= 1'b0;
      dma_end <= 1'b0;
    end else if (buf_rst) begin
      len_q   <= '0;
      rx_cnt  <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      rdy     <= 2'b00;
      buf0    <= 8'h00;
      buf1    <= 8'h00;
      rx_ovf  <= 1'b0;
      dma_end <= 1'b0;
    end else begin
      dma_end <= dma_end_nxt;
      if (start_ok) begin
        len_q  <= blk_len;
        rx_cnt <= '0;
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
        rdy    <= 2'b00;
        rx_ovf <= 1'b0;
      end else begin
        rdy <= rdy_nxt;
        if (free_ok) rd_ptr <= ~rd_ptr;
        if (accept) begin
          if (wr_ptr) buf1 <= rx_byte;
          else        buf0 <= rx_byte;
          wr_ptr <= ~wr_ptr;
          rx_cnt <= rx_cnt + LEN'(1);
        end
        if (drop) rx_ovf <= 1'b1;
      end
    end
  end

`ifdef SDIO_RXBUF_OVF_CNT_EN
  logic [7:0] ovf_q;

  always_ff @(posedge bus_clk or negedge rstn) begin
    if (!rstn)                         ovf_q <= 8'h00;
    else if (buf_rst || start_ok)      ovf_q <= 8'h00;
    else if (drop && (ovf_q != 8'hFF)) ovf_q <= ovf_q + 8'd1;
  end

  assign ovf_cnt = ovf_q;
`else
  assign ovf_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_sdio_rx_pingpong.sv
// Self-checking bench for sdio_rx_pingpong: a DMA model pops expected slot/data pairs from a scoreboard.
// Build with SDIO_RXBUF_OVF_CNT_EN defined to check the saturating overflow counter.
module tb_sdio_rx_pingpong;
  localparam int LEN = 16;

`ifdef SDIO_RXBUF_OVF_CNT_EN
  localparam logic [7:0] OVF_ONE = 8'h01;
  localparam logic [7:0] OVF_300 = 8'hFF;
`else
  localparam logic [7:0] OVF_ONE = 8'h00;
  localparam logic [7:0] OVF_300 = 8'h00;
`endif

  logic           bus_clk = 1'b0;
  logic           rstn = 1'b0;
  logic           buf_rst = 1'b0;
  logic           rx_start = 1'b0;
  logic [LEN-1:0] blk_len = '0;
  logic           rx_byte_en = 1'b0;
  logic [7:0]     rx_byte = 8'h00;
  logic           dma_free = 1'b0;
  logic           man_free = 1'b0;
  logic           buf_free;
  logic [7:0]     buf0, buf1;
  logic           buf0_rd_rdy, buf1_rd_rdy, rx_ready, rx_ovf, dma_end;
  logic [LEN-1:0] rx_cnt;
  logic [7:0]     ovf_cnt;
  logic [1:0]     rx_state;

  assign buf_free = dma_free | man_free;

  sdio_rx_pingpong #(.LEN(LEN)) dut (
    .bus_clk    (bus_clk),
    .rstn       (rstn),
    .buf_rst    (buf_rst),
    .rx_start   (rx_start),
    .blk_len    (blk_len),
    .rx_byte_en (rx_byte_en),
    .rx_byte    (rx_byte),
    .buf_free   (buf_free),
    .buf0       (buf0),
    .buf1       (buf1),
    .buf0_rd_rdy(buf0_rd_rdy),
    .buf1_rd_rdy(buf1_rd_rdy),
    .rx_ready   (rx_ready),
    .rx_ovf     (rx_ovf),
    .dma_end    (dma_end),
    .rx_cnt     (rx_cnt),
    .ovf_cnt    (ovf_cnt),
    .rx_state   (rx_state)
  );

  always #5 bus_clk = ~bus_clk;

  int         tests = 0;
  int         fails = 0;
  logic [8:0] exp_q[$];
  logic       dma_en = 1'b0;
  logic       dma_rp = 1'b0;
  int         dma_end_cnt = 0;
  int         dma_end_long = 0;
  logic       dma_end_d = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, want);
    end
  endtask

  // DMA model and scoreboard monitor: latch the ready slot, compare, free it on the next edge.
  always @(negedge bus_clk) begin
    logic [8:0] e;
    if (dma_end) dma_end_cnt++;
    if (dma_end && dma_end_d) dma_end_long++;
    dma_end_d = dma_end;
    if (dma_free) begin
      dma_free = 1'b0;
      dma_rp   = ~dma_rp;
    end else if (dma_en && (dma_rp ? buf1_rd_rdy : buf0_rd_rdy)) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL dma_unexpected_byte: slot %0d data %0h, expected no byte", dma_rp,
                 dma_rp ? buf1 : buf0);
      end else begin
        e = exp_q.pop_front();
        check("dma_slot_data", {23'd0, dma_rp, (dma_rp ? buf1 : buf0)}, {23'd0, e});
      end
      dma_free = 1'b1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge bus_clk);
    #1;
  endtask

  task automatic start(input logic [LEN-1:0] n);
    blk_len  = n;
    dma_rp   = 1'b0;
    rx_start = 1'b1;
    tick();
    rx_start = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input int gap);
    rx_byte    = d;
    rx_byte_en = 1'b1;
    tick();
    rx_byte_en = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic soft_reset();
    buf_rst = 1'b1;
    tick();
    buf_rst = 1'b0;
  endtask

  task automatic wait_end(input string nm);
    logic got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge bus_clk);
      if (dma_end) got = 1'b1;
    end
    check(nm, {31'd0, got}, 32'd1);
    tick();
  endtask

  initial begin
    int         base;
    logic [1:0] st_tab[4];
    logic       de_tab[4];
    logic [7:0] c_tab[8];

    repeat (3) tick();
    rstn = 1'b1;
    tick();
    @(negedge bus_clk);
    check("rst_state",   {30'd0, rx_state}, 32'd0);
    check("rst_rdy",     {30'd0, buf1_rd_rdy, buf0_rd_rdy}, 32'd0);
    check("rst_bufs",    {16'd0, buf1, buf0}, 32'd0);
    check("rst_cnt",     {16'd0, rx_cnt}, 32'd0);
    check("rst_ovf",     {23'd0, rx_ovf, ovf_cnt}, 32'd0);
    check("rst_dma_end", {31'd0, dma_end}, 32'd0);
    check("rst_ready",   {31'd0, rx_ready}, 32'd0);

    // Bytes in IDLE are ignored without raising overflow.
    tick();
    send(8'h5A, 0);
    @(negedge bus_clk);
    check("idle_ignore_rdy", {30'd0, buf1_rd_rdy, buf0_rd_rdy}, 32'd0);
    check("idle_ignore_ovf", {31'd0, rx_ovf}, 32'd0);
    check("idle_ignore_buf", {24'd0, buf0}, 32'd0);

    // 1: four spaced bytes, DMA draining.
    tick();
    dma_en = 1'b1;
    base   = dma_end_cnt;
    exp_q.push_back({1'b0, 8'hA0});
    exp_q.push_back({1'b1, 8'hA1});
    exp_q.push_back({1'b0, 8'hA2});
    exp_q.push_back({1'b1, 8'hA3});
    start(16'd4);
    send(8'hA0, 2);
    send(8'hA1, 2);
    send(8'hA2, 2);
    send(8'hA3, 2);
    wait_end("t1_dma_end");
    check("t1_rx_cnt",  {16'd0, rx_cnt}, 32'd4);
    check("t1_rx_ovf",  {31'd0, rx_ovf}, 32'd0);
    check("t1_q_empty", exp_q.size(), 32'd0);
    repeat (3) tick();
    check("t1_end_pulses", dma_end_cnt - base, 32'd1);

    // 2: DMA stalled, third back-to-back byte dropped.
    dma_en = 1'b0;
    base   = dma_end_cnt;
    start(16'd3);
    rx_byte_en = 1'b1;
    rx_byte = 8'h11; tick();
    rx_byte = 8'h22; tick();
    rx_byte = 8'h33; tick();
    rx_byte_en = 1'b0;
    @(negedge bus_clk);
    check("t2_buf0",    {24'd0, buf0}, 32'h11);
    check("t2_buf1",    {24'd0, buf1}, 32'h22);
    check("t2_rdy",     {30'd0, buf1_rd_rdy, buf0_rd_rdy}, 32'd3);
    check("t2_rx_ovf",  {31'd0, rx_ovf}, 32'd1);
    check("t2_rx_cnt",  {16'd0, rx_cnt}, 32'd2);
    check("t2_ovf_cnt", {24'd0, ovf_cnt}, {24'd0, OVF_ONE});
    check("t2_state",   {30'd0, rx_state}, 32'd1);
    repeat (5) tick();
    check("t2_no_end", dma_end_cnt - base, 32'd0);
    soft_reset();

    // 3: same-cycle free and write of slot 0 (third byte, so the count has not yet completed).
    base = dma_end_cnt;
    start(16'd3);
    send(8'h55, 0);
    send(8'h66, 0);
    rx_byte    = 8'h77;
    rx_byte_en = 1'b1;
    man_free   = 1'b1;
    tick();
    rx_byte_en = 1'b0;
    man_free   = 1'b0;
    exp_q.push_back({1'b1, 8'h66});
    exp_q.push_back({1'b0, 8'h77});
    dma_rp = 1'b1;
    dma_en = 1'b1;
    @(negedge bus_clk);
    check("t3_buf0",   {24'd0, buf0}, 32'h77);
    check("t3_rdy",    {30'd0, buf1_rd_rdy, buf0_rd_rdy}, 32'd3);
    check("t3_rx_cnt", {16'd0, rx_cnt}, 32'd3);
    check("t3_rd_ptr", {31'd0, dut.rd_ptr}, 32'd1);
    check("t3_wr_ptr", {31'd0, dut.wr_ptr}, 32'd1);
    wait_end("t3_dma_end");
    check("t3_q_empty", exp_q.size(), 32'd0);
    repeat (3) tick();
    check("t3_end_pulses", dma_end_cnt - base, 32'd1);

    // 4: zero-length transfer walks every state.
    dma_en = 1'b0;
    base   = dma_end_cnt;
    st_tab = '{2'd1, 2'd2, 2'd3, 2'd0};
    de_tab = '{1'b0, 1'b0, 1'b0, 1'b1};
    start(16'd0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      @(negedge bus_clk);
      check($sformatf("t4_state_%0d", i), {30'd0, rx_state}, {30'd0, st_tab[i]});
      check($sformatf("t4_dma_end_%0d", i), {31'd0, dma_end}, {31'd0, de_tab[i]});
    end
    tick();
    @(negedge bus_clk);
    check("t4_dma_end_drop", {31'd0, dma_end}, 32'd0);
    check("t4_end_pulses", dma_end_cnt - base, 32'd1);

    // 5: soft reset mid-transfer, then a clean 8-byte transfer.
    tick();
    dma_en = 1'b1;
    base   = dma_end_cnt;
    exp_q.push_back({1'b0, 8'hB0});
    exp_q.push_back({1'b1, 8'hB1});
    exp_q.push_back({1'b0, 8'hB2});
    start(16'd8);
    send(8'hB0, 2);
    send(8'hB1, 2);
    send(8'hB2, 0);
    soft_reset();
    @(negedge bus_clk);
    check("t5_state",   {30'd0, rx_state}, 32'd0);
    check("t5_rdy",     {30'd0, buf1_rd_rdy, buf0_rd_rdy}, 32'd0);
    check("t5_rx_cnt",  {16'd0, rx_cnt}, 32'd0);
    repeat (4) tick();
    check("t5_no_end",  dma_end_cnt - base, 32'd0);
    check("t5_q_empty", exp_q.size(), 32'd0);
    c_tab = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6, 8'hC7};
    for (int i = 0; i < 8; i++) exp_q.push_back({i[0], c_tab[i]});
    start(16'd8);
    for (int i = 0; i < 8; i++) send(c_tab[i], 2);
    wait_end("t5_dma_end");
    check("t5_rx_cnt_done", {16'd0, rx_cnt}, 32'd8);
    check("t5_q_empty_done", exp_q.size(), 32'd0);
    repeat (3) tick();
    check("t5_end_pulses", dma_end_cnt - base, 32'd1);

    // 6: 300 drops with the DMA stalled; rx_start mid-transfer is ignored.
    dma_en = 1'b0;
    start(16'd10);
    send(8'h01, 0);
    send(8'h02, 0);
    rx_byte_en = 1'b1;
    repeat (300) tick();
    rx_byte_en = 1'b0;
    start(16'd5);
    @(negedge bus_clk);
    check("t6_ovf_cnt", {24'd0, ovf_cnt}, {24'd0, OVF_300});
    check("t6_rx_ovf",  {31'd0, rx_ovf}, 32'd1);
    check("t6_rx_cnt",  {16'd0, rx_cnt}, 32'd2);
    check("t6_state",   {30'd0, rx_state}, 32'd1);
    tick();
    soft_reset();
    @(negedge bus_clk);
    check("t6_ovf_clr", {23'd0, rx_ovf, ovf_cnt}, 32'd0);

    check("dma_end_width", dma_end_long, 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
